sync_counter_bank: RTL and testbench



---
 rtl/sync_counter_bank.sv | 88 ++++++++
 tb/tb_sync_counter_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_counter_bank.sv
// Cascaded up/down counter bank with load, clear, modulus wrap and tristate q.
// Sub-stages chain like stacked 74xx counters; rco lets banks chain further.
module sync_counter_bank #(
    parameter int     N        = 8,
    parameter int     SIZE_SUB = 4,
    parameter longint MOD      = longint'(64'(1) << N)
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  clr_,
    input  logic                  load_,
    input  logic                  enp,
    input  logic                  ent,
    input  logic                  up,
    input  logic                  oe_,
    input  logic [N-1:0]          d,
    output logic [N-1:0]          q,
    output logic [N-1:0]          q_int,
    output logic                  rco,
    output logic [N/SIZE_SUB-1:0] stage_tc
);

    localparam int NS = N / SIZE_SUB;
    localparam logic [N-1:0] TOP = N'(MOD - 1);

    generate
        if ((N % SIZE_SUB) != 0 || MOD < 2 || MOD > longint'(64'(1) << N)) begin : g_bad_params
            $error("sync_counter_bank: illegal N/SIZE_SUB/MOD combination");
        end
    endgenerate

    logic [N-1:0]  cnt;
    logic [N-1:0]  casc;
    logic [N-1:0]  nxt;
    logic [NS-1:0] tc;
    logic [NS-1:0] carry_in;
    logic          run;
    logic          at_tc;

    assign run = enp & ent;

    // Each stage steps only when every lower stage sits at its terminal value.
    genvar k;
    generate
        for (k = 0; k < NS; k++) begin : g_stage
            logic [SIZE_SUB-1:0] sv;
            assign sv    = cnt[k*SIZE_SUB +: SIZE_SUB];
            assign tc[k] = up ? (&sv) : ~(|sv);
            if (k == 0) begin : g_first
                assign carry_in[k] = 1'b1;
            end else begin : g_rest
                assign carry_in[k] = carry_in[k-1] & tc[k-1];
            end
            assign casc[k*SIZE_SUB +: SIZE_SUB] = carry_in[k]
                ? (up ? sv + SIZE_SUB'(1) : sv - SIZE_SUB'(1))
                : sv;
        end
    endgenerate

    // The modulus wrap is judged on the whole value and overrides the cascade.
    always_comb begin
        nxt = casc;
        if (up && (cnt >= TOP)) begin
            nxt = '0;
        end else if (!up && (cnt == '0)) begin
            nxt = TOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            cnt <= '0;
        end else if (!clr_) begin
            cnt <= '0;
        end else if (!load_) begin
            cnt <= d;
        end else if (run) begin
            cnt <= nxt;
        end
    end

    assign at_tc    = up ? (cnt == TOP) : (cnt == '0);
    assign rco      = ent & at_tc;
    assign stage_tc = tc;
    assign q_int    = cnt;
    assign q        = oe_ ? {N{1'bz}} : cnt;

endmodule

// File: tb/tb_sync_counter_bank.sv
// Bench for sync_counter_bank: full-modulus bank, MOD=10 bank and a two-bank
// chain, all checked each cycle against an arithmetic model plus literal points.
module tb_sync_counter_bank;

    logic        clk = 1'b0;
    logic        reset_, clr_, load_, enp, ent, up, oe_;
    logic [7:0]  d;
    logic [15:0] d16;

    wire  [7:0]  qa, qb, ql, qh;
    logic [7:0]  ia, ib, il, ih;
    logic        ra, rb, rl, rh;
    logic [1:0]  ta, tb, tl, th;

    int n_chk  = 0;
    int n_fail = 0;
    int ma = 0, mb = 0, mc = 0;
    bit mvalid = 1'b0;

    always #5 clk = ~clk;

    sync_counter_bank u_a (
        .clk(clk), .reset_(reset_), .clr_(clr_), .load_(load_), .enp(enp),
        .ent(ent), .up(up), .oe_(oe_), .d(d), .q(qa), .q_int(ia),
        .rco(ra), .stage_tc(ta)
    );

    sync_counter_bank #(.N(8), .SIZE_SUB(4), .MOD(10)) u_b (
        .clk(clk), .reset_(reset_), .clr_(clr_), .load_(load_), .enp(enp),
        .ent(ent), .up(up), .oe_(oe_), .d(d), .q(qb), .q_int(ib),
        .rco(rb), .stage_tc(tb)
    );

    sync_counter_bank u_lo (
        .clk(clk), .reset_(reset_), .clr_(clr_), .load_(load_), .enp(enp),
        .ent(ent), .up(up), .oe_(oe_), .d(d16[7:0]), .q(ql), .q_int(il),
        .rco(rl), .stage_tc(tl)
    );

    sync_counter_bank u_hi (
        .clk(clk), .reset_(reset_), .clr_(clr_), .load_(load_), .enp(enp),
        .ent(rl), .up(up), .oe_(oe_), .d(d16[15:8]), .q(qh), .q_int(ih),
        .rco(rh), .stage_tc(th)
    );

    function automatic int nxt(int v, int md, int dv);
        if (!reset_) return 0;
        if (!clr_) return 0;
        if (!load_) return dv;
        if (enp && ent) begin
            if (up) return (v >= md - 1) ? 0 : v + 1;
            return (v == 0) ? md - 1 : v - 1;
        end
        return v;
    endfunction

    function automatic logic [1:0] tcf(int v, bit u);
        logic [1:0] r;
        for (int k = 0; k < 2; k++) begin
            r[k] = (((v >> (4 * k)) & 15) == (u ? 15 : 0));
        end
        return r;
    endfunction

    function automatic logic rcof(int v, int md, bit e, bit u);
        return e && (u ? (v == md - 1) : (v == 0));
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma <= nxt(ma, 256, int'(d));
        mb <= nxt(mb, 10, int'(d));
        mc <= nxt(mc, 65536, int'(d16));
        if (!reset_) mvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_a_q_int", 32'(ia), 32'(ma));
            chk("m_a_rco", 32'(ra), 32'(rcof(ma, 256, ent, up)));
            chk("m_a_stage_tc", 32'(ta), 32'(tcf(ma, up)));
            chk("m_b_q_int", 32'(ib), 32'(mb));
            chk("m_b_rco", 32'(rb), 32'(rcof(mb, 10, ent, up)));
            chk("m_b_stage_tc", 32'(tb), 32'(tcf(mb, up)));
            chk("m_chain", 32'({ih, il}), 32'(mc));
            chk("m_lo_rco", 32'(rl), 32'(rcof(mc & 255, 256, ent, up)));
            if (!oe_) begin
                chk("m_a_q", 32'(qa), 32'(ma));
            end else if (ma != 0) begin
                n_chk++;
                if (qa === 8'(ma)) begin
                    n_fail++;
                    $display("FAIL m_a_q_hiz: got %0h while oe_=1, required not driven", qa);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ = 1'b0; clr_ = 1'b1; load_ = 1'b0; enp = 1'b0;
        ent = 1'b1; up = 1'b0; oe_ = 1'b0; d = 8'h5A; d16 = 16'h0000;

        tick();
        chk("rst_a", 32'(ia), 32'h00);
        chk("rst_b", 32'(ib), 32'h00);
        chk("rst_rco_down", 32'(ra), 32'h1);
        up = 1'b1;
        #1;
        chk("rst_rco_up", 32'(ra), 32'h0);
        reset_ = 1'b1;

        load_ = 1'b0; d = 8'h0E;
        tick();
        chk("load_0e", 32'(ia), 32'h0E);
        load_ = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
        tick();
        chk("up_0f", 32'(ia), 32'h0F);
        chk("tc_0f", 32'(ta), 32'h1);
        tick();
        chk("up_10", 32'(ia), 32'h10);
        chk("tc_10", 32'(ta), 32'h0);
        tick();
        chk("up_11", 32'(ia), 32'h11);

        load_ = 1'b0; d = 8'hFF; enp = 1'b0;
        tick();
        load_ = 1'b1;
        #1;
        chk("rco_ff_up", 32'(ra), 32'h1);
        enp = 1'b1;
        tick();
        chk("wrap_00", 32'(ia), 32'h00);
        enp = 1'b0; up = 1'b0;
        #1;
        chk("rco_00_down", 32'(ra), 32'h1);
        enp = 1'b1;
        tick();
        chk("wrap_ff", 32'(ia), 32'hFF);

        up = 1'b1; reset_ = 1'b0;
        tick();
        chk("midcount_rst", 32'(ia), 32'h00);
        reset_ = 1'b1;

        clr_ = 1'b0;
        tick();
        chk("clr_b", 32'(ib), 32'h0);
        clr_ = 1'b1; enp = 1'b1; ent = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("mod10_up", 32'(ib), 32'(i % 10));
            chk("mod10_rco", 32'(rb), 32'((i % 10) == 9));
        end
        clr_ = 1'b0;
        tick();
        clr_ = 1'b1; up = 1'b0;
        tick();
        chk("mod10_down", 32'(ib), 32'h9);
        chk("mod256_down", 32'(ia), 32'hFF);

        clr_ = 1'b0; load_ = 1'b0; d = 8'h33;
        tick();
        chk("clr_over_load", 32'(ia), 32'h00);
        clr_ = 1'b1; enp = 1'b0; d = 8'h5C;
        tick();
        chk("load_no_enp", 32'(ia), 32'h5C);
        load_ = 1'b1; enp = 1'b0; ent = 1'b1;
        tick();
        chk("hold_enp0", 32'(ia), 32'h5C);
        load_ = 1'b0; d = 8'hFF;
        tick();
        load_ = 1'b1; enp = 1'b1; ent = 1'b0; up = 1'b1;
        tick();
        chk("hold_ent0", 32'(ia), 32'hFF);
        chk("rco_ent0", 32'(ra), 32'h0);

        load_ = 1'b0; d = 8'h21; d16 = 16'h00FF; enp = 1'b0; ent = 1'b1;
        tick();
        chk("chain_load", 32'({ih, il}), 32'h00FF);
        load_ = 1'b1; oe_ = 1'b1; enp = 1'b1; up = 1'b1;
        tick();
        chk("chain_carry", 32'({ih, il}), 32'h0100);
        chk("hiz_count", 32'(ia), 32'h22);
        tick();
        chk("hiz_count2", 32'(ia), 32'h23);
        oe_ = 1'b0;
        #1;
        chk("oe_on", 32'(qa), 32'h23);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
